// File: rtl/aes128_enc_seq.sv
// rtl/aes128_enc_seq.sv - iterative AES-128 encryption engine, one round per clock
//
// Purpose: accepts a plaintext/key pair over a valid/ready handshake, runs the
// ten AES-128 rounds through one shared combinational round datapath with an
// on-the-fly key-schedule step, and presents the ciphertext over a second
// valid/ready handshake.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   in_valid    plaintext/key offered
//   in_ready    engine idle and able to accept a job
//   plaintext   128-bit block, byte 0 at [127:120], column-major
//   key         128-bit cipher key, same byte order
//   out_valid   ciphertext available
//   out_ready   consumer accepts ciphertext
//   ciphertext  128-bit result, same byte order
//   busy        rounds in progress
//   round       round being computed (1..10), 0 otherwise

module aes128_enc_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic [3:0]   round
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        // Entry b occupies bits [2047-8b -: 8]; {~b, 3'b111} is that top bit.
        idx = {~b, 3'b111};
        return SBOX_TBL[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[7'(127 - 8 * i) -: 8] = sbox(s[7'(127 - 8 * i) -: 8]);
        end
        return r;
    endfunction

    // Byte (row rr, column c) sits at index 4c+rr; row rr rotates left by rr.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                r[7'(127 - 8 * (4 * c + rr)) -: 8] =
                    s[7'(127 - 8 * (4 * ((c + rr) % 4) + rr)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[7'(127 - 32 * c) -: 32] = mix_column(s[7'(127 - 32 * c) -: 32]);
        end
        return r;
    endfunction

    state_t         fsm_q;
    logic [127:0]   state_q;
    logic [127:0]   rk_q;
    logic [127:0]   ct_q;
    logic [7:0]     rcon_q;
    logic [3:0]     round_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           busy_q;

    // Key-schedule step: next round key derived from the current one.
    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    w0_n, w1_n, w2_n, w3_n;
    logic [127:0]   rk_d;

    assign w0   = rk_q[127:96];
    assign w1   = rk_q[95:64];
    assign w2   = rk_q[63:32];
    assign w3   = rk_q[31:0];
    assign w0_n = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rcon_q, 24'h0};
    assign w1_n = w1 ^ w0_n;
    assign w2_n = w2 ^ w1_n;
    assign w3_n = w3 ^ w2_n;
    assign rk_d = {w0_n, w1_n, w2_n, w3_n};

    // Shared round datapath; the final round skips MixColumns.
    logic [127:0]   sr_state;
    logic [127:0]   state_d;

    assign sr_state = shift_rows(sub_bytes(state_q));
    assign state_d  = ((round_q == 4'd10) ? sr_state : mix_columns(sr_state)) ^ rk_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= S_IDLE;
            state_q     <= '0;
            rk_q        <= '0;
            ct_q        <= '0;
            rcon_q      <= 8'h00;
            round_q     <= 4'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    // in_ready is registered, so it rises one cycle after reset.
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        state_q    <= plaintext ^ key;
                        rk_q       <= key;
                        round_q    <= 4'd1;
                        rcon_q     <= 8'h01;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                        fsm_q      <= S_RUN;
                    end
                end
                S_RUN: begin
                    state_q <= state_d;
                    rk_q    <= rk_d;
                    rcon_q  <= xtime(rcon_q);
                    if (round_q == 4'd10) begin
                        round_q     <= 4'd0;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        ct_q        <= state_d;
                        fsm_q       <= S_DONE;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= S_IDLE;
                    end
                end
                default: begin
                    fsm_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign round      = round_q;
    assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes128_enc_seq.sv
// tb/tb_aes128_enc_seq.sv - self-checking bench for aes128_enc_seq

module tb_aes128_enc_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;
    logic [3:0]   round;

    always #5 clk = ~clk;

    aes128_enc_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy),
        .round      (round)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: GF(2^8) arithmetic, S-box derived from the field inverse
    // plus affine map, full key expansion up front, byte-array rounds.
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_m[x] = s;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc, t0;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) w[i] = k[127 - 8 * i -: 8];
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i - 4 + j];
            if (i % 16 == 0) begin
                t0     = tmp[0];
                tmp[0] = sbox_m[tmp[1]] ^ rc;
                tmp[1] = sbox_m[tmp[2]];
                tmp[2] = sbox_m[tmp[3]];
                tmp[3] = sbox_m[t0];
                rc     = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i + j] = w[i - 16 + j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[4 * c + rr] = s[4 * ((c + rr) % 4) + rr];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    if (r < 10)
                        s[4 * c + rr] = gmul(8'h02, t[4 * c + rr]) ^ gmul(8'h03, t[4 * c + (rr + 1) % 4])
                                      ^ t[4 * c + (rr + 2) % 4] ^ t[4 * c + (rr + 3) % 4];
                    else
                        s[4 * c + rr] = t[4 * c + rr];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16 * r + i];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        int           hold;
    } vec_t;

    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_R1  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    task automatic wait_ready();
        int waited;
        waited = 0;
        while (!in_ready && waited < 30) begin
            step();
            waited++;
        end
        check("wait_in_ready", 128'(in_ready), 128'd1);
    endtask

    // One complete job: accept, per-round status, result, optional back-pressure, drain.
    task automatic run_job(input logic [127:0] pt_i, input logic [127:0] key_i,
                           input logic [127:0] exp_ct, input bit chk_r1, input int hold);
        wait_ready();
        plaintext = pt_i;
        key       = key_i;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            check("round_index", 128'(round), 128'(k));
            check("run_flags{busy,ovalid,iready}", 128'({busy, out_valid, in_ready}), 128'(3'b100));
            if (chk_r1 && k == 2) check("state_after_round1", dut.state_q, B_R1);
            step();
        end
        check("done_flags{busy,ovalid,iready}", 128'({busy, out_valid, in_ready}), 128'(3'b010));
        check("done_round", 128'(round), 128'd0);
        check("ciphertext", ciphertext, exp_ct);
        for (int h = 0; h < hold; h++) begin
            step();
            check("bp_flags{ovalid,iready}", 128'({out_valid, in_ready}), 128'(2'b10));
            check("bp_ciphertext", ciphertext, exp_ct);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("drain_flags{ovalid,iready}", 128'({out_valid, in_ready}), 128'(2'b01));
    endtask

    vec_t vecs [6];

    initial begin
        logic [127:0] q_ct;
        logic [127:0] exp_q [$];
        int           accepts [$];
        int           cyc, got, nacc;
        bit           acc, hs;
        logic [127:0] ct_s;

        build_sbox();

        vecs[0] = '{pt: B_PT, key: B_KEY, ct: B_CT, hold: 0};
        vecs[1] = '{pt: C_PT, key: C_KEY, ct: C_CT, hold: 7};
        for (int i = 2; i < 6; i++) begin
            vecs[i].pt   = rand128();
            vecs[i].key  = rand128();
            vecs[i].ct   = aes_ref(vecs[i].pt, vecs[i].key);
            vecs[i].hold = i % 3;
        end

        // Reset with in_valid asserted: reset must win.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        plaintext = C_PT;
        key       = C_KEY;
        step();
        step();
        check("reset_flags{iready,ovalid,busy}", 128'({in_ready, out_valid, busy}), 128'd0);
        check("reset_round", 128'(round), 128'd0);
        check("reset_ciphertext", ciphertext, 128'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        check("post_reset_in_ready", 128'(in_ready), 128'd1);

        // Known-answer and random vectors, with back-pressure on some.
        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].pt, vecs[i].key, vecs[i].ct, i == 0, vecs[i].hold);
        end

        // Busy rejection: a second job held on the input during RUN.
        wait_ready();
        plaintext = C_PT;
        key       = C_KEY;
        in_valid  = 1'b1;
        step();
        plaintext = B_PT;
        key       = B_KEY;
        for (int k = 0; k < 10; k++) begin
            check("busy_reject_in_ready", 128'(in_ready), 128'd0);
            step();
        end
        check("busy_reject_out_valid", 128'(out_valid), 128'd1);
        check("busy_reject_first_ct", ciphertext, C_CT);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("busy_reject_handshake{iready,busy}", 128'({in_ready, busy}), 128'(2'b10));
        step();
        in_valid = 1'b0;
        check("busy_reject_second_accept{busy,round}", 128'({busy, round}), 128'({1'b1, 4'd1}));
        repeat (10) step();
        check("busy_reject_second_ovalid", 128'(out_valid), 128'd1);
        check("busy_reject_second_ct", ciphertext, B_CT);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset in the middle of round 5, then a clean C.1 run.
        wait_ready();
        plaintext = C_PT;
        key       = C_KEY;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        repeat (4) step();
        check("midreset_at_round5", 128'(round), 128'd5);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        plaintext = B_PT;
        key       = B_KEY;
        step();
        check("midreset_flags{iready,ovalid,busy}", 128'({in_ready, out_valid, busy}), 128'd0);
        check("midreset_round", 128'(round), 128'd0);
        rst_n = 1'b1;
        step();
        in_valid = 1'b0;
        check("midreset_release_in_ready", 128'(in_ready), 128'd1);
        check("midreset_release_busy", 128'(busy), 128'd0);
        q_ct = '0;
        for (int k = 0; k < 15; k++) begin
            q_ct[0] = q_ct[0] | out_valid;
            step();
        end
        check("midreset_no_spurious_ovalid", q_ct, 128'd0);
        run_job(C_PT, C_KEY, C_CT, 1'b0, 0);

        // Back-to-back random jobs with no back-pressure.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        plaintext = rand128();
        key       = rand128();
        cyc  = 0;
        got  = 0;
        nacc = 0;
        while (got < 4 && cyc < 100) begin
            acc  = in_valid && in_ready;
            hs   = out_valid && out_ready;
            ct_s = ciphertext;
            if (acc) exp_q.push_back(aes_ref(plaintext, key));
            step();
            cyc++;
            if (acc) begin
                accepts.push_back(cyc);
                nacc++;
                if (nacc == 4) begin
                    in_valid = 1'b0;
                end else begin
                    plaintext = rand128();
                    key       = rand128();
                end
            end
            if (hs) begin
                got++;
                if (exp_q.size() > 0) check("b2b_ciphertext", ct_s, exp_q.pop_front());
                else check("b2b_unexpected_output", 128'd1, 128'd0);
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("b2b_outputs_seen", 128'(got), 128'd4);
        check("b2b_accepts_seen", 128'(accepts.size()), 128'd4);
        for (int i = 1; i < accepts.size(); i++) begin
            check("b2b_accept_spacing", 128'(accepts[i] - accepts[i - 1]), 128'd12);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
